// File: rtl/mesh_generator_if.sv
// Terminal-side bundle of the mesh: per-terminal input offer handshake and
// per-terminal output FIFO handshake. The mesh uses master, terminals use slave.
interface mesh_generator_if #(
    parameter int unsigned N_TERM  = 16,
    parameter int unsigned PCKG_SZ = 40
);
    logic [N_TERM-1:0][PCKG_SZ-1:0] data_out_i_in;
    logic [N_TERM-1:0]              pndng_i_in;
    logic [N_TERM-1:0]              popin;
    logic [N_TERM-1:0][PCKG_SZ-1:0] data_out;
    logic [N_TERM-1:0]              pndng;
    logic [N_TERM-1:0]              pop;

    modport master (
        input  data_out_i_in, pndng_i_in, pop,
        output popin, data_out, pndng
    );

    modport slave (
        output data_out_i_in, pndng_i_in, pop,
        input  popin, data_out, pndng
    );
endinterface

// File: rtl/mesh_generator.sv
// Edge-terminal packet mesh: round-robin single-grant arbiter feeding
// per-terminal show-ahead output FIFOs with unicast/broadcast delivery.
module mesh_generator #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLUMS     = 4,
    parameter int unsigned pckg_sz    = 40,
    parameter int unsigned fifo_depth = 4,
    parameter logic [7:0]  bdcst      = 8'hFF
) (
    input logic              clk,
    input logic              reset,
    mesh_generator_if.master bus
);
    localparam int unsigned N    = 2 * (ROWS + COLUMS);
    localparam int unsigned IDXW = $clog2(N);
    localparam int unsigned PTRW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned CNTW = $clog2(fifo_depth + 1);

    // Border address {row,col} of terminal t, walking top, left, bottom, right.
    function automatic logic [7:0] term_addr(input int unsigned t);
        logic [3:0] r;
        logic [3:0] c;
        if (t < COLUMS) begin
            r = '0;
            c = 4'(t + 1);
        end else if (t < COLUMS + ROWS) begin
            r = 4'(t - COLUMS + 1);
            c = '0;
        end else if (t < 2 * COLUMS + ROWS) begin
            r = 4'(ROWS + 1);
            c = 4'(t - COLUMS - ROWS + 1);
        end else begin
            r = 4'(t - 2 * COLUMS - ROWS + 1);
            c = 4'(COLUMS + 1);
        end
        return {r, c};
    endfunction

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(fifo_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [IDXW-1:0]           ptr_q, ptr_d;
    logic [N-1:0][CNTW-1:0]    cnt_q, cnt_d;
    logic [N-1:0][PTRW-1:0]    rd_q, rd_d;
    logic [N-1:0][PTRW-1:0]    wr_q, wr_d;
    logic [pckg_sz-1:0]        mem_q [N][fifo_depth];

    logic [N-1:0][N-1:0]       dst_mask;
    logic [N-1:0]              elig;
    logic                      gnt_vld;
    logic [IDXW-1:0]           gnt_idx;
    int unsigned               arb_idx;
    logic [N-1:0]              wr_en;
    logic [N-1:0]              rd_en;
    logic [pckg_sz-1:0]        wr_data;

    // A requester is eligible only when every FIFO it would write has room.
    always_comb begin
        dst_mask = '0;
        elig     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.data_out_i_in[i][pckg_sz-9 -: 8] == bdcst) begin
                dst_mask[i]    = '1;
                dst_mask[i][i] = 1'b0;
            end else begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (bus.data_out_i_in[i][pckg_sz-9 -: 8] == term_addr(j))
                        dst_mask[i][j] = 1'b1;
                end
            end
            elig[i] = bus.pndng_i_in[i];
            for (int unsigned j = 0; j < N; j++) begin
                if (dst_mask[i][j] && (cnt_q[j] == CNTW'(fifo_depth)))
                    elig[i] = 1'b0;
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_idx = 0;
        for (int unsigned k = 0; k < N; k++) begin
            arb_idx = k + 32'(ptr_q);
            if (arb_idx >= N) arb_idx = arb_idx - N;
            if (!gnt_vld && elig[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDXW'(arb_idx);
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld && !reset)
            ptr_d = (gnt_idx == IDXW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Invalid destinations leave dst_mask empty: the packet is popped and dropped.
    always_comb begin
        bus.popin = '0;
        wr_en     = '0;
        wr_data   = bus.data_out_i_in[gnt_idx];
        if (gnt_vld && !reset) begin
            bus.popin[gnt_idx] = 1'b1;
            wr_en              = dst_mask[gnt_idx];
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        rd_en        = '0;
        bus.pndng    = '0;
        bus.data_out = '0;
        for (int unsigned j = 0; j < N; j++) begin
            rd_en[j] = bus.pop[j] && (cnt_q[j] != '0);
            if (wr_en[j]) wr_d[j] = ptr_inc(wr_q[j]);
            if (rd_en[j]) rd_d[j] = ptr_inc(rd_q[j]);
            cnt_d[j]        = cnt_q[j] + CNTW'(wr_en[j]) - CNTW'(rd_en[j]);
            bus.pndng[j]    = (cnt_q[j] != '0);
            bus.data_out[j] = (cnt_q[j] != '0) ? mem_q[j][rd_q[j]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N; j++) begin
            if (wr_en[j]) mem_q[j][wr_q[j]] <= wr_data;
        end
    end
endmodule

// File: tb/tb_mesh_generator.sv
// Directed bench for mesh_generator: reset, unicast, broadcast, full FIFO,
// contention, invalid address and mid-traffic reset.
module tb_mesh_generator;
    localparam int unsigned N = 16;
    localparam int unsigned W = 40;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mesh_generator_if #(.N_TERM(N), .PCKG_SZ(W)) bus ();

    mesh_generator #(
        .ROWS(4), .COLUMS(4), .pckg_sz(W), .fifo_depth(4), .bdcst(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                        input logic [15:0] pl);
        return {8'h3C, r, c, 1'b0, 7'h00, pl};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pndng_i_in = '0;
        bus.pop = '0;
        bus.data_out_i_in = '0;
        repeat (2) step();
        checks++;
        if (bus.pndng !== '0) begin
            failures++; $display("FAIL reset_pndng got=%h exp=0", bus.pndng);
        end
        checks++;
        if (bus.popin !== '0) begin
            failures++; $display("FAIL reset_popin got=%h exp=0", bus.popin);
        end
        checks++;
        if (bus.data_out !== '0) begin
            failures++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out);
        end
        reset = 1'b0;
        step();
        checks++;
        if (bus.pndng !== '0) begin
            failures++; $display("FAIL reset_release_pndng got=%h exp=0", bus.pndng);
        end
    endtask

    task automatic test_unicast();
        logic [W-1:0] pkt;
        pkt = mk(4'd5, 4'd2, 16'h1234);
        bus.data_out_i_in[0] = pkt;
        bus.pndng_i_in[0] = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0001) begin
            failures++; $display("FAIL uni_popin got=%h exp=0001", bus.popin);
        end
        step();
        bus.pndng_i_in[0] = 1'b0;
        #1;
        checks++;
        if (bus.popin !== 16'h0000) begin
            failures++; $display("FAIL uni_popin_pulse got=%h exp=0000", bus.popin);
        end
        checks++;
        if (bus.pndng !== 16'h0200) begin
            failures++; $display("FAIL uni_pndng got=%h exp=0200", bus.pndng);
        end
        checks++;
        if (bus.data_out[9] !== pkt) begin
            failures++; $display("FAIL uni_data got=%h exp=%h", bus.data_out[9], pkt);
        end
        bus.pop[9] = 1'b1;
        step();
        bus.pop[9] = 1'b0;
        #1;
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL uni_after_pop got=%h exp=0000", bus.pndng);
        end
    endtask

    task automatic test_broadcast();
        logic [W-1:0] pkt;
        pkt = mk(4'hF, 4'hF, 16'hBEEF);
        bus.data_out_i_in[4] = pkt;
        bus.pndng_i_in[4] = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0010) begin
            failures++; $display("FAIL bc_popin got=%h exp=0010", bus.popin);
        end
        step();
        bus.pndng_i_in[4] = 1'b0;
        #1;
        checks++;
        if (bus.popin !== 16'h0000) begin
            failures++; $display("FAIL bc_popin_pulse got=%h exp=0000", bus.popin);
        end
        checks++;
        if (bus.pndng !== 16'hFFEF) begin
            failures++; $display("FAIL bc_pndng got=%h exp=ffef", bus.pndng);
        end
        for (int j = 0; j < N; j++) begin
            if (j != 4) begin
                checks++;
                if (bus.data_out[j] !== pkt) begin
                    failures++;
                    $display("FAIL bc_data[%0d] got=%h exp=%h", j, bus.data_out[j], pkt);
                end
            end
        end
        checks++;
        if (bus.data_out[4] !== '0) begin
            failures++; $display("FAIL bc_src_empty got=%h exp=0", bus.data_out[4]);
        end
        bus.pop = '1;
        step();
        bus.pop = '0;
        #1;
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL bc_drain got=%h exp=0000", bus.pndng);
        end
    endtask

    task automatic test_full_fifo();
        int unsigned src[5] = '{5, 6, 8, 9, 10};
        logic [N-1:0] exp;
        logic [W-1:0] pkt;
        for (int s = 0; s < 5; s++) begin
            bus.data_out_i_in[src[s]] = mk(4'd1, 4'd5, 16'hA000 + 16'(src[s]));
            bus.pndng_i_in[src[s]] = 1'b1;
        end
        #1;
        for (int s = 0; s < 4; s++) begin
            exp = '0;
            exp[src[s]] = 1'b1;
            checks++;
            if (bus.popin !== exp) begin
                failures++; $display("FAIL full_grant%0d got=%h exp=%h", s, bus.popin, exp);
            end
            step();
            bus.pndng_i_in[src[s]] = 1'b0;
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.popin !== 16'h0000) begin
                failures++; $display("FAIL full_blocked%0d got=%h exp=0000", c, bus.popin);
            end
            step();
            #1;
        end
        checks++;
        if (bus.pndng[12] !== 1'b1) begin
            failures++; $display("FAIL full_pndng12 got=%b exp=1", bus.pndng[12]);
        end
        bus.pop[12] = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0000) begin
            failures++; $display("FAIL full_pop_cycle got=%h exp=0000", bus.popin);
        end
        step();
        bus.pop[12] = 1'b0;
        #1;
        checks++;
        if (bus.popin !== 16'h0400) begin
            failures++; $display("FAIL full_after_pop got=%h exp=0400", bus.popin);
        end
        step();
        bus.pndng_i_in[10] = 1'b0;
        for (int s = 1; s < 5; s++) begin
            #1;
            pkt = mk(4'd1, 4'd5, 16'hA000 + 16'(src[s]));
            checks++;
            if (bus.data_out[12] !== pkt) begin
                failures++; $display("FAIL full_order%0d got=%h exp=%h", s, bus.data_out[12], pkt);
            end
            bus.pop[12] = 1'b1;
            step();
            bus.pop[12] = 1'b0;
        end
        #1;
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL full_drain got=%h exp=0000", bus.pndng);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        logic [W-1:0] pkt;
        for (int s = 1; s <= 3; s++) begin
            bus.data_out_i_in[s] = mk(4'd4, 4'd5, 16'hC000 + 16'(s));
            bus.pndng_i_in[s] = 1'b1;
        end
        #1;
        for (int s = 1; s <= 3; s++) begin
            exp = '0;
            exp[s] = 1'b1;
            checks++;
            if (bus.popin !== exp) begin
                failures++; $display("FAIL cont_grant%0d got=%h exp=%h", s, bus.popin, exp);
            end
            step();
            bus.pndng_i_in[s] = 1'b0;
            #1;
        end
        for (int s = 1; s <= 3; s++) begin
            pkt = mk(4'd4, 4'd5, 16'hC000 + 16'(s));
            checks++;
            if (bus.data_out[15] !== pkt) begin
                failures++; $display("FAIL cont_order%0d got=%h exp=%h", s, bus.data_out[15], pkt);
            end
            bus.pop[15] = 1'b1;
            step();
            bus.pop[15] = 1'b0;
            #1;
        end
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL cont_drain got=%h exp=0000", bus.pndng);
        end
    endtask

    task automatic test_invalid();
        bus.data_out_i_in[7] = mk(4'd0, 4'd0, 16'hDEAD);
        bus.pndng_i_in[7] = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0080) begin
            failures++; $display("FAIL inv_popin got=%h exp=0080", bus.popin);
        end
        step();
        bus.pndng_i_in[7] = 1'b0;
        #1;
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL inv_pndng got=%h exp=0000", bus.pndng);
        end
        repeat (2) step();
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL inv_pndng_later got=%h exp=0000", bus.pndng);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] pkt0;
        pkt0 = mk(4'd5, 4'd2, 16'h0F00);
        bus.data_out_i_in[0] = pkt0;
        bus.data_out_i_in[1] = mk(4'd1, 4'd5, 16'h0F01);
        bus.pndng_i_in[0] = 1'b1;
        bus.pndng_i_in[1] = 1'b1;
        step();
        bus.pndng_i_in[0] = 1'b0;
        step();
        bus.pndng_i_in[1] = 1'b0;
        #1;
        checks++;
        if (bus.pndng !== 16'h1200) begin
            failures++; $display("FAIL rst_pre_pndng got=%h exp=1200", bus.pndng);
        end
        bus.data_out_i_in[2] = mk(4'd4, 4'd5, 16'h0F02);
        bus.pndng_i_in[2] = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0000) begin
            failures++; $display("FAIL rst_popin_gated got=%h exp=0000", bus.popin);
        end
        checks++;
        if (bus.pndng !== 16'h0000) begin
            failures++; $display("FAIL rst_async_pndng got=%h exp=0000", bus.pndng);
        end
        step();
        reset = 1'b0;
        bus.pndng_i_in[2] = 1'b0;
        step();
        checks++;
        if (bus.data_out !== '0) begin
            failures++; $display("FAIL rst_data_out got=%h exp=0", bus.data_out);
        end
        checks++;
        if ((bus.pndng !== '0) || (bus.popin !== '0)) begin
            failures++; $display("FAIL rst_stay_zero got=%h/%h exp=0/0", bus.pndng, bus.popin);
        end
        bus.data_out_i_in[3] = mk(4'd5, 4'd2, 16'h0F03);
        bus.pndng_i_in[0] = 1'b1;
        bus.pndng_i_in[3] = 1'b1;
        #1;
        checks++;
        if (bus.popin !== 16'h0001) begin
            failures++; $display("FAIL rst_ptr_first got=%h exp=0001", bus.popin);
        end
        step();
        bus.pndng_i_in[0] = 1'b0;
        #1;
        checks++;
        if (bus.popin !== 16'h0008) begin
            failures++; $display("FAIL rst_ptr_second got=%h exp=0008", bus.popin);
        end
        step();
        bus.pndng_i_in[3] = 1'b0;
        #1;
        checks++;
        if (bus.data_out[9] !== pkt0) begin
            failures++; $display("FAIL rst_new_data got=%h exp=%h", bus.data_out[9], pkt0);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_full_fifo();
        test_contention();
        test_invalid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
